// File: rtl/usart_rx_fifo.sv
// usart_rx_fifo: asynchronous serial receiver (start + DATA_BITS LSB first + stop)
// feeding a word FIFO that the CPU drains one word per rising edge of controle.
// Sticky framing/overrun flags, cleared by clr_err.
// Optional feature: define USART_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit; otherwise parity_err is tied low.
module usart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int OUT_W        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          controle,
  input  logic                          clr_err,
  output logic [OUT_W-1:0]              dado,
  output logic                          dado_pronto,
  output logic                          habilitar,
  output logic [$clog2(FIFO_DEPTH):0]   nivel,
  output logic                          framing_err,
  output logic                          overrun,
  output logic                          parity_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

`ifdef USART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [BW-1:0]          bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   push_reg, push_next;
  logic                   framing_evt;
  logic                   rx_meta_reg, rx_sync_reg, rx_prev_reg;
  logic                   ctrl_reg;
  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]          count_reg;
  logic [OUT_W-1:0]       dado_reg;
  logic                   framing_err_reg, overrun_reg;
  logic                   full, empty, pop_req, do_pop, do_push, overrun_evt;
`ifdef USART_PARITY_EN
  logic                   par_bad_reg, par_bad_next, parity_evt, parity_err_reg;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  // Receiver state, bit timing counters and the deferred push request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      push_reg  <= 1'b0;
`ifdef USART_PARITY_EN
      par_bad_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      push_reg  <= push_next;
`ifdef USART_PARITY_EN
      par_bad_reg <= par_bad_next;
`endif
    end
  end

  // Next-state logic: the falling edge arms, half a bit later the start is confirmed,
  // then every full bit period a sample is taken. Re-arming after a low stop bit
  // needs rx to return high first, which the edge detector enforces naturally.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    push_next   = 1'b0;
    framing_evt = 1'b0;
`ifdef USART_PARITY_EN
    par_bad_next = par_bad_reg;
    parity_evt   = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        bit_next = '0;
`ifdef USART_PARITY_EN
        par_bad_next = 1'b0;
`endif
        if (rx_prev_reg && !rx_sync_reg) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_sync_reg ? S_IDLE : S_DATA;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync_reg, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == BITS_LAST) begin
            bit_next = '0;
`ifdef USART_PARITY_EN
            state_next = S_PARITY;
`else
            state_next = S_STOP;
`endif
          end else begin
            bit_next = bit_reg + BW'(1);
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`ifdef USART_PARITY_EN
      S_PARITY: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = S_STOP;
          if (rx_sync_reg != ^shift_reg) begin
            parity_evt   = 1'b1;
            par_bad_next = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          state_next = S_IDLE;
          if (!rx_sync_reg) begin
            framing_evt = 1'b1;
          end else begin
`ifdef USART_PARITY_EN
            push_next = !par_bad_reg;
`else
            push_next = 1'b1;
`endif
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign full        = (count_reg == LW'(FIFO_DEPTH));
  assign empty       = (count_reg == '0);
  assign pop_req     = controle && !ctrl_reg;
  assign do_pop      = pop_req && !empty;
  assign do_push     = push_reg && (!full || do_pop);
  assign overrun_evt = push_reg && full && !do_pop;

  // FIFO storage, no reset so it maps onto RAM; written only when the push is accepted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= shift_reg;
  end

  // Pointers, occupancy and the registered read port; a pop reads the old head even
  // when a push to the same slot happens on that edge (full FIFO, simultaneous ops).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_reg   <= 1'b0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dado_reg   <= '0;
    end else begin
      ctrl_reg <= controle;
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        dado_reg   <= OUT_W'(mem[rd_ptr_reg]);
      end
      if (do_push && !do_pop)      count_reg <= count_reg + LW'(1);
      else if (!do_push && do_pop) count_reg <= count_reg - LW'(1);
    end
  end

  // Sticky error flags; a new error event beats a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      framing_err_reg <= 1'b0;
      overrun_reg     <= 1'b0;
`ifdef USART_PARITY_EN
      parity_err_reg  <= 1'b0;
`endif
    end else begin
      if (framing_evt)  framing_err_reg <= 1'b1;
      else if (clr_err) framing_err_reg <= 1'b0;
      if (overrun_evt)  overrun_reg <= 1'b1;
      else if (clr_err) overrun_reg <= 1'b0;
`ifdef USART_PARITY_EN
      if (parity_evt)   parity_err_reg <= 1'b1;
      else if (clr_err) parity_err_reg <= 1'b0;
`endif
    end
  end

  assign dado        = dado_reg;
  assign nivel       = count_reg;
  assign dado_pronto = !empty;
  assign habilitar   = (state_reg != S_IDLE);
  assign framing_err = framing_err_reg;
  assign overrun     = overrun_reg;
`ifdef USART_PARITY_EN
  assign parity_err  = parity_err_reg;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx_fifo.sv
// Testbench for usart_rx_fifo: directed vector table, hand-written corner sequences
// and randomized traffic checked against a queue-based model of the receiver.
module tb_usart_rx_fifo;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
  localparam int OUT_W = 32;
  localparam int OP_SEND = 0;
  localparam int OP_POP  = 1;
  localparam int OP_CLR  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx = 1'b1;
  logic             controle = 1'b0;
  logic             clr_err = 1'b0;
  logic [OUT_W-1:0] dado;
  logic             dado_pronto, habilitar, framing_err, overrun, parity_err;
  logic [3:0]       nivel;

  usart_rx_fifo #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .controle(controle), .clr_err(clr_err),
    .dado(dado), .dado_pronto(dado_pronto), .habilitar(habilitar), .nivel(nivel),
    .framing_err(framing_err), .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO as a queue, flags as bits, last popped word.
  logic [7:0]  m_q[$];
  bit          m_fe, m_ov, m_pe;
  logic [31:0] m_dado;

  int n_checks = 0;
  int n_fail   = 0;
  int fall_nivel, post_nivel;

  typedef struct {
    int          op;
    logic [7:0]  data;
    bit          stop_ok;
    int          exp_nivel;
    logic [31:0] exp_dado;
    bit          exp_fe;
    bit          exp_ov;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(int op, logic [7:0] d, bit s, int n, logic [31:0] dd, bit fe, bit ov);
    vec_t v;
    v.op = op; v.data = d; v.stop_ok = s; v.exp_nivel = n;
    v.exp_dado = dd; v.exp_fe = fe; v.exp_ov = ov;
    return v;
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic check_state(string tag, int en, logic [31:0] ed, bit efe, bit eov, bit epe);
    check({tag, "_nivel"}, 32'(nivel), 32'(en));
    check({tag, "_pronto"}, 32'(dado_pronto), 32'(en != 0));
    check({tag, "_dado"}, dado, ed);
    check({tag, "_framing"}, 32'(framing_err), 32'(efe));
    check({tag, "_overrun"}, 32'(overrun), 32'(eov));
    check({tag, "_parity"}, 32'(parity_err), 32'(epe));
    check({tag, "_habilitar"}, 32'(habilitar), 32'd0);
  endtask

  // Frame-level model: parity is flagged at its own bit, framing at stop, and a good
  // frame lands in the queue unless it is full (a same-edge pop makes room first).
  task automatic model_frame(logic [7:0] d, bit stop_ok, bit par_ok, bit sim_pop);
    if (sim_pop && m_q.size() > 0) m_dado = 32'(m_q.pop_front());
    if (!par_ok) m_pe = 1'b1;
    if (!stop_ok) m_fe = 1'b1;
    else if (par_ok) begin
      if (m_q.size() == DEPTH) m_ov = 1'b1;
      else m_q.push_back(d);
    end
  endtask

  task automatic model_pop();
    if (m_q.size() > 0) m_dado = 32'(m_q.pop_front());
  endtask

  // Drive one serial frame; records nivel around the end of reception and can raise
  // controle so the pop lands on the same edge as the push.
  task automatic send_frame(logic [7:0] d, bit stop_ok, bit par_ok, bit pop_at_end, int idle_clks);
    bit fall_seen;
    bit post_pending;
    bit popped;
    fall_seen = 0; post_pending = 0; popped = 0;
    fall_nivel = -1; post_nivel = -1;
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef USART_PARITY_EN
    rx = par_ok ? ^d : ~(^d);
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_ok;
    for (int i = 0; i < CPB; i++) begin
      @(negedge clk);
      if (post_pending) begin
        post_nivel = 32'(nivel);
        post_pending = 0;
      end
      if (!fall_seen && !habilitar) begin
        fall_seen = 1;
        fall_nivel = 32'(nivel);
        post_pending = 1;
        if (pop_at_end) begin
          controle = 1'b1;
          popped = 1;
        end
      end
    end
    controle = 1'b0;
    rx = 1'b1;
    if (pop_at_end) check("pop_window", 32'(popped), 32'd1);
    repeat (idle_clks) @(negedge clk);
    $display("send 0x%02h stop_ok=%0d par_ok=%0d pop_at_end=%0d -> nivel=%0d", d, stop_ok, par_ok, pop_at_end, nivel);
  endtask

  task automatic do_send(logic [7:0] d, bit stop_ok, bit par_ok);
    send_frame(d, stop_ok, par_ok, 1'b0, (stop_ok && par_ok) ? 4 : CPB + 4);
    model_frame(d, stop_ok, par_ok, 1'b0);
  endtask

  task automatic do_pop();
    @(negedge clk);
    controle = 1'b1;
    @(negedge clk);
    model_pop();
    check("pop_dado_next_cycle", dado, m_dado);
    controle = 1'b0;
    repeat (2) @(negedge clk);
    $display("pop -> dado=0x%08h nivel=%0d", dado, nivel);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_fe = 0; m_ov = 0; m_pe = 0;
    $display("clr_err -> framing=%0d overrun=%0d parity=%0d", framing_err, overrun, parity_err);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_hab;
    m_fe = 0; m_ov = 0; m_pe = 0; m_dado = '0;

    // Directed vectors with hand-derived expectations.
    vecs.push_back(mk(OP_SEND, 8'hA5, 1, 1, 32'h0, 0, 0));
    vecs.push_back(mk(OP_POP,  8'h00, 1, 0, 32'hA5, 0, 0));
    vecs.push_back(mk(OP_SEND, 8'h3C, 0, 0, 32'hA5, 1, 0));
    vecs.push_back(mk(OP_CLR,  8'h00, 1, 0, 32'hA5, 0, 0));
    for (int i = 1; i <= 9; i++)
      vecs.push_back(mk(OP_SEND, 8'(i), 1, (i <= 8) ? i : 8, 32'hA5, 0, i == 9));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(OP_POP, 8'h00, 1, 8 - i, 32'(i), 0, 1));
    vecs.push_back(mk(OP_POP, 8'h00, 1, 0, 32'h08, 0, 1));
    vecs.push_back(mk(OP_CLR, 8'h00, 1, 0, 32'h08, 0, 0));

    // Reset state.
    repeat (3) @(negedge clk);
    check_state("reset", 0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      case (vecs[k].op)
        OP_SEND: do_send(vecs[k].data, vecs[k].stop_ok, 1'b1);
        OP_POP:  do_pop();
        default: do_clr();
      endcase
      check_state($sformatf("vec%0d", k), vecs[k].exp_nivel, vecs[k].exp_dado,
                  vecs[k].exp_fe, vecs[k].exp_ov, 1'b0);
    end

    // Push latency: occupancy changes one clock after reception ends.
    do_send(8'h5A, 1, 1);
    check("lat_at_end", 32'(fall_nivel), 32'd0);
    check("lat_next_clk", 32'(post_nivel), 32'd1);
    do_pop();
    check_state("lat_pop", 0, 32'h5A, 0, 0, 0);

    // Short low glitch on an idle line is rejected.
    seen_hab = 0;
    @(negedge clk);
    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (habilitar) seen_hab = 1;
    end
    $display("glitch 5 clks -> habilitar_seen=%0d nivel=%0d", seen_hab, nivel);
    check("glitch_hab_seen", 32'(seen_hab), 32'd1);
    check_state("glitch", 0, 32'h5A, 0, 0, 0);

    // Full FIFO with a pop on the same edge as the ninth push.
    for (int i = 0; i < 8; i++) do_send(8'h10 + 8'(i), 1, 1);
    check("full_nivel", 32'(nivel), 32'd8);
    send_frame(8'h18, 1, 1, 1, 4);
    model_frame(8'h18, 1, 1, 1);
    check("simul_nivel", 32'(nivel), 32'd8);
    check("simul_overrun", 32'(overrun), 32'd0);
    check("simul_dado", dado, 32'h10);
    for (int i = 0; i < 8; i++) begin
      do_pop();
      check_state($sformatf("drain%0d", i), m_q.size(), m_dado, m_fe, m_ov, m_pe);
    end
    check("drain_last", dado, 32'h18);

    // Reset in the middle of a frame, then a clean frame.
    do_send(8'h77, 1, 1);
    do_send(8'hC3, 0, 1);
    check("pre_rst_fe", 32'(framing_err), 32'd1);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = 1'(8'h55 >> i);
      repeat (CPB) @(negedge clk);
    end
    check("pre_rst_hab", 32'(habilitar), 32'd1);
    check("pre_rst_nivel", 32'(nivel), 32'd1);
    rst = 1'b1;
    #1;
    $display("reset mid-frame -> nivel=%0d habilitar=%0d", nivel, habilitar);
    check_state("midrst", 0, 32'h0, 0, 0, 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    m_q.delete(); m_fe = 0; m_ov = 0; m_pe = 0; m_dado = '0;
    repeat (4) @(negedge clk);
    do_send(8'h66, 1, 1);
    check_state("post_rst_rx", 1, 32'h0, 0, 0, 0);
    do_pop();
    check_state("post_rst_pop", 0, 32'h66, 0, 0, 0);

`ifdef USART_PARITY_EN
    do_send(8'h07, 1, 0);
    check_state("par_bad", 0, 32'h66, 0, 0, 1);
    do_send(8'h07, 1, 1);
    check_state("par_good", 1, 32'h66, 0, 0, 1);
    do_pop();
    check("par_pop", dado, 32'h07);
    do_clr();
`endif

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      int r;
      bit par_ok;
      r = $urandom_range(0, 9);
      par_ok = 1;
`ifdef USART_PARITY_EN
      par_ok = ($urandom_range(0, 5) != 0);
`endif
      if (r <= 5) do_send(8'($urandom), $urandom_range(0, 7) != 0, par_ok);
      else if (r <= 8) do_pop();
      else do_clr();
      check_state($sformatf("rnd%0d", k), m_q.size(), m_dado, m_fe, m_ov, m_pe);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
